mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter.sv | 79 +++++++
 tb/tb_mux4_rr_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that funnels four valid/ready producers through one shared
// 4:1 mux into a single registered output stage.
module mux4_rr_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   in_valid,
    input  logic [W-1:0] in_data0,
    input  logic [W-1:0] in_data1,
    input  logic [W-1:0] in_data2,
    input  logic [W-1:0] in_data3,
    output logic [3:0]   in_ready,
    output logic [1:0]   sel,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);

    // Handshake: a word moves on any rising edge where valid and ready are both
    // high; in_ready is one-hot and depends combinationally on out_ready.
    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic [1:0]   r_last;

    logic [1:0]   w_winner;
    logic [1:0]   w_cand;
    logic         w_found;
    logic         w_can_accept;
    logic         w_accept;
    logic [W-1:0] w_mux;

    // Scan from the requester after the last winner; with no request the
    // winner defaults to last+1 so sel is always defined.
    always_comb begin
        w_winner = r_last + 2'd1;
        w_found  = 1'b0;
        w_cand   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_last + 2'(k);
            if (!w_found && in_valid[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        case (w_winner)
            2'd0:    w_mux = in_data0;
            2'd1:    w_mux = in_data1;
            2'd2:    w_mux = in_data2;
            default: w_mux = in_data3;
        endcase
    end

    assign w_can_accept = !r_out_valid || out_ready;
    assign w_accept     = rst_n && w_can_accept && (|in_valid);

    assign in_ready  = w_accept ? (4'b0001 << w_winner) : 4'b0000;
    assign sel       = w_winner;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_last      <= 2'd3;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_mux;
            r_last      <= w_winner;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios followed by a
// randomized run, all checked against a priority-queue reference model.
module tb_mux4_rr_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [W-1:0] d [4];
  logic [3:0]   in_ready;
  logic [1:0]   sel;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  int tests;
  int fails;

  // Reference model: priority order as a queue (head = highest priority),
  // plus the contents of the output register.
  int           prio_q[$];
  logic         m_valid;
  logic [W-1:0] m_data;

  mux4_rr_arbiter #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data0  (d[0]),
    .in_data1  (d[1]),
    .in_data2  (d[2]),
    .in_data3  (d[3]),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_winner();
    foreach (prio_q[k]) if (in_valid[prio_q[k]]) return prio_q[k];
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int w;
    w = model_winner();
    if (!rst_n || w < 0 || (m_valid && !out_ready)) return 4'b0000;
    return 4'b0001 << w;
  endfunction

  function automatic logic [1:0] model_sel();
    int w;
    w = model_winner();
    if (w < 0) return 2'(prio_q[0]);
    return 2'(w);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [3:0] g;
    int w;
    int p;
    g = model_ready();
    w = model_winner();
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      prio_q  = '{0, 1, 2, 3};
    end else if (g != 4'b0000) begin
      m_valid = 1'b1;
      m_data  = d[w];
      do begin
        p = prio_q.pop_front();
        prio_q.push_back(p);
      end while (p != w);
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) d[i] = W'(32'hA0 + i);
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++;
      if (in_ready !== 4'b0000) begin
        fails++; $display("FAIL reset_in_ready got=%b want=0000", in_ready);
      end
      tick();
      tests++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
        fails++; $display("FAIL reset_out got valid=%b data=%h want valid=0 data=0", out_valid, out_data);
      end
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0001 || sel !== 2'd0) begin
      fails++; $display("FAIL reset_first_grant got ready=%b sel=%0d want ready=0001 sel=0", in_ready, sel);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_ir [5];
    exp_ir = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if (in_ready !== exp_ir[k] || in_ready !== model_ready()) begin
        fails++; $display("FAIL rotation_ready[%0d] got=%b want=%b", k, in_ready, exp_ir[k]);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== W'(32'hA0 + (k % 4))) begin
        fails++; $display("FAIL rotation_data[%0d] got valid=%b data=%h want valid=1 data=%h",
                          k, out_valid, out_data, 32'hA0 + (k % 4));
      end
    end
  endtask

  task automatic test_backpressure();
    tick();
    tests++;
    if (out_data !== W'(32'hA1)) begin
      fails++; $display("FAIL bp_load got=%h want=a1", out_data);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (in_ready !== 4'b0000 || sel !== 2'd2) begin
        fails++; $display("FAIL bp_hold_comb[%0d] got ready=%b sel=%0d want ready=0000 sel=2", c, in_ready, sel);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== W'(32'hA1)) begin
        fails++; $display("FAIL bp_hold_data[%0d] got valid=%b data=%h want valid=1 data=a1", c, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0100) begin
      fails++; $display("FAIL bp_release_ready got=%b want=0100", in_ready);
    end
    tick();
    tests++;
    if (out_data !== W'(32'hA2)) begin
      fails++; $display("FAIL bp_release_data got=%h want=a2", out_data);
    end
  endtask

  task automatic test_sparse();
    logic [3:0] exp_g [2];
    exp_g = '{4'b1000, 4'b0001};
    in_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++;
      if (in_ready !== 4'b0100) begin
        fails++; $display("FAIL sparse_single[%0d] got=%b want=0100", c, in_ready);
      end
      tick();
    end
    in_valid = 4'b1001;
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++;
      if (in_ready !== exp_g[c]) begin
        fails++; $display("FAIL sparse_skip[%0d] got=%b want=%b", c, in_ready, exp_g[c]);
      end
      tick();
    end
  endtask

  task automatic test_drain();
    logic [W-1:0] held;
    held = m_data;
    in_valid = 4'b0000; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0000) begin
      fails++; $display("FAIL drain_ready got=%b want=0000", in_ready);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_data !== held || sel !== 2'd1) begin
      fails++; $display("FAIL drain got valid=%b data=%h sel=%0d want valid=0 data=%h sel=1",
                        out_valid, out_data, sel, held);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 4'b1000; out_ready = 1'b1;
    tick();
    in_valid = 4'b0000; out_ready = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b1 || out_data !== W'(32'hA3)) begin
      fails++; $display("FAIL midrst_pre got valid=%b data=%h want valid=1 data=a3", out_valid, out_data);
    end
    rst_n = 1'b0;
    tick();
    tests++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      fails++; $display("FAIL midrst_clear got valid=%b data=%h want valid=0 data=0", out_valid, out_data);
    end
    rst_n = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 4'b0001 || sel !== 2'd0) begin
      fails++; $display("FAIL midrst_first_grant got ready=%b sel=%0d want ready=0001 sel=0", in_ready, sel);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] exp_q[$];
    for (int c = 0; c < 400; c++) begin
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 9) < 7);
      rst_n     = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      #1;
      tests++;
      if (in_ready !== model_ready() || sel !== model_sel()) begin
        fails++; $display("FAIL rand_comb[%0d] got ready=%b sel=%0d want ready=%b sel=%0d",
                          c, in_ready, sel, model_ready(), model_sel());
      end
      tick();
      exp_q.push_back(m_data);
      tests++;
      if (out_valid !== m_valid || out_data !== exp_q[0]) begin
        fails++; $display("FAIL rand_out[%0d] got valid=%b data=%h want valid=%b data=%h",
                          c, out_valid, out_data, m_valid, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0;
    m_valid = 1'b0; m_data = '0;
    prio_q = '{0, 1, 2, 3};
    rst_n = 1'b0; in_valid = 4'b0000; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    @(negedge clk);
    test_reset();
    test_rotation();
    test_backpressure();
    test_sparse();
    test_drain();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
